// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit field layout and injection arbiter state encoding
// Provides: FLIT_W, destination/payload field positions, arb_state_t (INIT/RUN/PAUSED).
package noc_pkg;

    localparam int FLIT_W          = 20;
    localparam int DEST_CLUSTER_HI = 19;
    localparam int DEST_CLUSTER_LO = 18;
    localparam int DEST_LOCAL_HI   = 17;
    localparam int DEST_LOCAL_LO   = 16;
    localparam int PAYLOAD_W       = 16;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - N-way round-robin pick starting at a pointer
// Ports: req (N) request vector, ptr (PTR_W) highest-priority index,
//        en (1) allow any grant, grant (N) one-hot or all-zero result.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     grant
);

    int               sum;
    logic [PTR_W-1:0] idx;
    logic             found;

    // Walk the requesters from ptr upward, wrapping at N; first hit wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = 0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            sum = int'(ptr) + k;
            if (sum >= N) begin
                sum = sum - N;
            end
            idx = PTR_W'(sum);
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/inject_arbiter.sv
// rtl/inject_arbiter.sv - round-robin, credit-tracked sharing of a router injection port
// Ports: clk, rst (sync active-high); req_valid/req_flit/req_ready requester side;
//        pause stops new grants; credit_in slot-freed pulse from router;
//        inj_flit/inj_valid registered router injection; credits count; err_credit sticky overflow.
// Optional (INJ_ARB_STATS_EN): stat_clr input, stat_count per-requester accepted-flit counters.
module inject_arbiter #(
    parameter int N_REQ     = 4,
    parameter int FLIT_W    = noc_pkg::FLIT_W,
    parameter int BUF_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*FLIT_W-1:0] req_flit,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    pause,
`ifdef INJ_ARB_STATS_EN
    input  logic                    stat_clr,
    output logic [N_REQ*16-1:0]     stat_count,
`endif
    input  logic                    credit_in,
    output logic [FLIT_W-1:0]       inj_flit,
    output logic                    inj_valid,
    output logic [3:0]              credits,
    output logic                    err_credit
);

    import noc_pkg::*;

    localparam int PTR_W = $clog2(N_REQ);

    arb_state_t        state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [3:0]        credits_q, credits_d;
    logic [FLIT_W-1:0] inj_flit_q, inj_flit_d;
    logic              inj_valid_q, inj_valid_d;
    logic              err_credit_q, err_credit_d;

    logic              grant_en;
    logic [N_REQ-1:0]  grant;
    logic              any_grant;
    logic [PTR_W-1:0]  gidx;

    rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .en    (grant_en),
        .grant (grant)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    state_d = RUN;
            RUN:     if (pause)  state_d = PAUSED;
            PAUSED:  if (!pause) state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // FSM: outputs. Grant needs a free slot now; a credit arriving this cycle only helps next cycle.
    always_comb begin
        grant_en = (state_q == RUN) && !pause && (credits_q != 4'd0);
    end

    always_comb begin
        gidx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                gidx = PTR_W'(i);
            end
        end
    end

    assign any_grant = |grant;

    always_comb begin
        credits_d    = credits_q;
        err_credit_d = err_credit_q;
        rr_ptr_d     = rr_ptr_q;
        inj_valid_d  = any_grant;
        inj_flit_d   = inj_flit_q;

        if (state_q == INIT) begin
            credits_d = 4'(BUF_DEPTH);
        end else if (any_grant && !credit_in) begin
            credits_d = credits_q - 4'd1;
        end else if (!any_grant && credit_in) begin
            if (credits_q == 4'(BUF_DEPTH)) begin
                err_credit_d = 1'b1;
            end else begin
                credits_d = credits_q + 4'd1;
            end
        end

        if (any_grant) begin
            inj_flit_d = req_flit[int'(gidx)*FLIT_W +: FLIT_W];
            rr_ptr_d   = (gidx == PTR_W'(N_REQ - 1)) ? '0 : gidx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            credits_q    <= '0;
            inj_flit_q   <= '0;
            inj_valid_q  <= 1'b0;
            err_credit_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            credits_q    <= credits_d;
            inj_flit_q   <= inj_flit_d;
            inj_valid_q  <= inj_valid_d;
            err_credit_q <= err_credit_d;
        end
    end

    assign req_ready  = grant;
    assign inj_flit   = inj_flit_q;
    assign inj_valid  = inj_valid_q;
    assign credits    = credits_q;
    assign err_credit = err_credit_q;

`ifdef INJ_ARB_STATS_EN
    logic [15:0] stat_q [N_REQ];
    logic [15:0] stat_d [N_REQ];

    // Clear wins over a same-cycle increment; counters wrap naturally at 16 bits.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            stat_d[i] = stat_q[i];
            if (stat_clr) begin
                stat_d[i] = '0;
            end else if (grant[i]) begin
                stat_d[i] = stat_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (rst) begin
                stat_q[i] <= '0;
            end else begin
                stat_q[i] <= stat_d[i];
            end
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stat_out
        assign stat_count[gi*16 +: 16] = stat_q[gi];
    end
`endif

endmodule

// File: tb/tb_inject_arbiter.sv
// tb/tb_inject_arbiter.sv - directed self-checking bench for inject_arbiter
module tb_inject_arbiter;

    localparam int N_REQ  = 4;
    localparam int FLIT_W = 20;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*FLIT_W-1:0] req_flit;
    logic [N_REQ-1:0]        req_ready;
    logic                    pause;
    logic                    credit_in;
    logic [FLIT_W-1:0]       inj_flit;
    logic                    inj_valid;
    logic [3:0]              credits;
    logic                    err_credit;
`ifdef INJ_ARB_STATS_EN
    logic                    stat_clr;
    logic [N_REQ*16-1:0]     stat_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [FLIT_W-1:0] flits [N_REQ];

    inject_arbiter #(
        .N_REQ     (N_REQ),
        .FLIT_W    (FLIT_W),
        .BUF_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_flit   (req_flit),
        .req_ready  (req_ready),
        .pause      (pause),
`ifdef INJ_ARB_STATS_EN
        .stat_clr   (stat_clr),
        .stat_count (stat_count),
`endif
        .credit_in  (credit_in),
        .inj_flit   (inj_flit),
        .inj_valid  (inj_valid),
        .credits    (credits),
        .err_credit (err_credit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        flits[0] = 20'h10A00;
        flits[1] = 20'h51B11;
        flits[2] = 20'h92C22;
        flits[3] = 20'hD3D33;
        for (int i = 0; i < N_REQ; i++) begin
            req_flit[i*FLIT_W +: FLIT_W] = flits[i];
        end
        rst       = 1'b1;
        req_valid = '0;
        pause     = 1'b0;
        credit_in = 1'b0;
`ifdef INJ_ARB_STATS_EN
        stat_clr  = 1'b0;
`endif

        // Reset state
        tick();
        tick();
        chk("rst_inj_valid", 32'(inj_valid), 32'd0);
        chk("rst_inj_flit", 32'(inj_flit), 32'd0);
        chk("rst_credits", 32'(credits), 32'd0);
        chk("rst_err", 32'(err_credit), 32'd0);

        // INIT cycle: no grant even with all requesters valid
        rst       = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("init_no_ready", 32'(req_ready), 32'd0);
        tick();
        chk("init_credits", 32'(credits), 32'd4);

        // Round robin 0,1,2,3,0,1 with credit returned every cycle
        credit_in = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            tick();
            chk("rr_inj_valid", 32'(inj_valid), 32'd1);
            chk("rr_inj_flit", 32'(inj_flit), 32'(flits[k % 4]));
            chk("rr_credits", 32'(credits), 32'd4);
        end

        // Idle: valid drops, flit holds
        credit_in = 1'b0;
        req_valid = '0;
        tick();
        chk("idle_inj_valid", 32'(inj_valid), 32'd0);
        chk("idle_flit_hold", 32'(inj_flit), 32'(flits[1]));

        // Requester 2 alone, no credit returns: exactly four grants
        req_valid = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("drain_ready", 32'(req_ready), 32'b0100);
            tick();
            chk("drain_credits", 32'(credits), 32'(3 - k));
        end
        chk("zero_ready", 32'(req_ready), 32'd0);
        tick();
        chk("zero_inj_valid", 32'(inj_valid), 32'd0);
        chk("zero_ready_held", 32'(req_ready), 32'd0);

        // One credit pulse: no same-cycle bypass, one grant next cycle
        credit_in = 1'b1;
        #1;
        chk("bypass_ready", 32'(req_ready), 32'd0);
        tick();
        credit_in = 1'b0;
        chk("refill_credits", 32'(credits), 32'd1);
        chk("refill_ready", 32'(req_ready), 32'b0100);
        tick();
        chk("refill_inj_valid", 32'(inj_valid), 32'd1);
        chk("refill_inj_flit", 32'(inj_flit), 32'(flits[2]));
        chk("refill_credits0", 32'(credits), 32'd0);
        chk("refill_ready0", 32'(req_ready), 32'd0);

        // Build credits up to 2, then grant and credit together
        req_valid = '0;
        credit_in = 1'b1;
        tick();
        tick();
        chk("two_credits", 32'(credits), 32'd2);
        req_valid = 4'b0100;
        #1;
        chk("simul_ready", 32'(req_ready), 32'b0100);
        tick();
        chk("simul_credits", 32'(credits), 32'd2);
        chk("simul_inj_valid", 32'(inj_valid), 32'd1);

        // rr_ptr is now 3; requester 1 alone wins, pause rises right after that grant
        credit_in = 1'b0;
        req_valid = 4'b0010;
        #1;
        chk("pause_pre_ready", 32'(req_ready), 32'b0010);
        tick();
        pause     = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("pause_flit_valid", 32'(inj_valid), 32'd1);
        chk("pause_flit", 32'(inj_flit), 32'(flits[1]));
        chk("pause_credits", 32'(credits), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk("paused_ready", 32'(req_ready), 32'd0);
            credit_in = (k == 2);
            tick();
            chk("paused_inj_valid", 32'(inj_valid), 32'd0);
        end
        credit_in = 1'b0;
        chk("paused_credit_counted", 32'(credits), 32'd2);

        // Release: still PAUSED this cycle, then requester 2 next
        pause = 1'b0;
        #1;
        chk("release_ready0", 32'(req_ready), 32'd0);
        tick();
        chk("release_ready", 32'(req_ready), 32'b0100);
        tick();
        chk("release_flit", 32'(inj_flit), 32'(flits[2]));
        chk("release_credits", 32'(credits), 32'd1);

        // rst the cycle after a grant: registered flit discarded
        chk("prerst_inj_valid", 32'(inj_valid), 32'd1);
        rst       = 1'b1;
        req_valid = '0;
        tick();
        chk("midrst_inj_valid", 32'(inj_valid), 32'd0);
        chk("midrst_credits", 32'(credits), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
`ifdef INJ_ARB_STATS_EN
        chk("midrst_stats", 32'(stat_count == '0), 32'd1);
`endif

        // credit_in during INIT is ignored
        rst       = 1'b0;
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        chk("init_credit_ignored", 32'(credits), 32'd4);
        chk("init_no_err", 32'(err_credit), 32'd0);

        // Overflow: credit while full with no grant
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        chk("ovf_credits", 32'(credits), 32'd4);
        chk("ovf_err", 32'(err_credit), 32'd1);
        tick();
        tick();
        chk("ovf_err_sticky", 32'(err_credit), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ovf_err_cleared", 32'(err_credit), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inject_arbiter.md
Name: inject_arbiter

Overview:
- Shares a node's single router injection port (router input 5: flit, valid, credit-return) among N local traffic sources, e.g. PE output queues and a config/debug source.
- Performs round-robin arbitration.
- Tracks router injection-buffer occupancy with a credit counter, so no flit is ever sent into a full buffer.
- Sits between the requesters and the router inside a node wrapper; its registered output drives the router's injection flit and valid, and the router's injection credit-return output feeds its credit input.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- FLIT_W, 20, flit width. Bits [19:18] are destination cluster, [17:16] destination local, [15:0] payload.
- BUF_DEPTH, 4, router injection-buffer depth; initial and maximum credit count (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  N_REQ  per-requester flit valid
- req_flit  in  N_REQ*FLIT_W  packed flits; requester i at [i*FLIT_W +: FLIT_W]
- req_ready  out  N_REQ  one-hot grant; the flit is accepted in the cycle where valid and ready are both high
- pause  in  1  stop issuing new grants
- credit_in  in  1  one-cycle pulse from the router: one injection-buffer slot freed
- inj_flit  out  FLIT_W  flit to router injection input (registered)
- inj_valid  out  1  flit valid to router (registered, one-cycle pulse per flit)
- credits  out  4  current credit count
- err_credit  out  1  sticky error: credit overflow

Behaviour:
- Reset values (rst synchronous, active-high, dominant over all other inputs):
  - FSM = INIT; rr_ptr = 0; credits = 0.
  - inj_flit = 0, inj_valid = 0, err_credit = 0.
  - req_ready = 0 while in INIT.
- FSM states:
  - INIT: one cycle; loads credits = BUF_DEPTH, then goes to RUN.
  - RUN: arbitrates. pause = 1 moves to PAUSED at the next edge.
  - PAUSED: no grants; credit returns are still counted. pause = 0 returns to RUN at the next edge.
- Grant rule (combinational, RUN only, credits > 0 and pause = 0):
  - Grant the first requester with req_valid = 1, searching from rr_ptr upward modulo N_REQ.
  - req_ready is one-hot or all-zero.
  - req_ready never depends on inj_valid; it depends only on state, pause, credits, req_valid and rr_ptr.
- On a grant to requester g:
  - Next cycle: inj_flit = req_flit[g] and inj_valid = 1.
  - rr_ptr becomes (g+1) mod N_REQ.
  - Latency from accept to router is exactly 1 cycle.
  - Back-to-back grants are allowed: one flit per cycle while credits last.
- No grant: inj_valid = 0, inj_flit holds its previous value, rr_ptr unchanged.
- Credit arithmetic:
  - next = credits − grant + credit_in.
  - Grant and credit_in in the same cycle leaves credits unchanged.
  - credits = 0: no grant, even if requests are pending. A credit_in that cycle allows a grant next cycle (no same-cycle bypass).
  - credit_in arriving while credits = BUF_DEPTH with no grant that cycle: credits saturate at BUF_DEPTH and err_credit is set. err_credit clears only on rst.
  - credit_in during INIT is ignored (the counter is loaded).
- Pause mid-stream: a flit granted in the cycle pause rises is still delivered the next cycle; no grant is issued afterwards.
- A requester may drop req_valid without being granted; no state is affected.
- rst asserted mid-operation:
  - Any flit registered but not yet seen by the router is discarded (inj_valid = 0 next cycle).
  - Credits are reinitialised via INIT. The router must be reset by the same rst.

Optional Feature:
- Macro INJ_ARB_STATS_EN.
- Defined: adds output stat_count (N_REQ*16), holding a per-requester count of accepted flits.
  - Each count increments on that requester's grant, wraps at 0xFFFF, and resets to 0 on rst.
  - Adds input stat_clr (1); stat_clr = 1 zeroes all counts that cycle and takes priority over an increment.
- Undefined: neither port exists and no counter logic is generated. Arbitration behaviour is identical either way.

Decomposition:
- Shared package noc_pkg holds:
  - FLIT_W and the flit field positions (DEST_CLUSTER_HI/LO, DEST_LOCAL_HI/LO, PAYLOAD_W = 16).
  - The FSM state encoding, a 2-bit typedef: INIT = 0, RUN = 1, PAUSED = 2.
- One sub-module is natural: rr_arbiter, a parameterised N-way round-robin pick. Inputs: req vector, pointer, enable. Output: one-hot grant.
- Credit counter, FSM and output register stay in inject_arbiter.

Test Plan:
- Reset, then all four requesters valid every cycle with credit_in tied high from cycle 2:
  - Grants in order 0,1,2,3,0,1 on consecutive cycles.
  - inj_valid high continuously from cycle 2; inj_flit equals the granted requester's flit one cycle later.
- Single requester 2 valid, credit_in = 0:
  - Exactly 4 grants (BUF_DEPTH), credits reaches 0, then req_ready stays 0.
  - One credit_in pulse gives exactly one more grant, on the cycle after the pulse.
- Simultaneous grant and credit_in with credits = 2: credits stays 2; inj_valid = 1 next cycle.
- After INIT with no traffic, pulse credit_in once: credits stays 4 and err_credit = 1, held until rst.
- pause asserted in the same cycle as a grant to requester 1:
  - The flit still appears the next cycle, then no grants for 5 cycles.
  - On release, the next grant goes to requester 2 if valid.
- rst asserted the cycle after a grant: inj_valid = 0 next cycle, credits = 0, then 4 after INIT. With INJ_ARB_STATS_EN defined, all stat_count fields read 0.
